// File: rtl/osd_tracepacket_pkg.sv
// Shared types and constants for the trace packetizer: FSM states and FLAGS
// word encoding for event vs. overflow trace packets.
package osd_tracepacket_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEST,
    ST_SRC,
    ST_FLAGS,
    ST_TS_LO,
    ST_TS_HI,
    ST_PAYLOAD
  } state_t;

  localparam logic [1:0] FLAGS_TYPE       = 2'b10;
  localparam logic [3:0] SUBTYPE_EVENT    = 4'h0;
  localparam logic [3:0] SUBTYPE_OVERFLOW = 4'h5;

  function automatic logic [15:0] flags_word(input logic ovf);
    return {FLAGS_TYPE, (ovf ? SUBTYPE_OVERFLOW : SUBTYPE_EVENT), 10'h000};
  endfunction

endpackage

// File: rtl/osd_tracepacket.sv
// Pops one trace FIFO entry at a time and serializes it into a 16-bit debug
// packet: DEST, SRC, FLAGS, TS_LO, TS_HI, then the payload words.
module osd_tracepacket
  import osd_tracepacket_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      id,
  input  logic [15:0]      dest,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             sample_overflow,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic [15:0]      flit_data,
  output logic             flit_last,
  output logic             flit_valid,
  input  logic             flit_ready
);

  localparam int NWORDS = WIDTH / 16;
  localparam int IDXW   = $clog2(NWORDS) + 1;

  state_t                      state, state_nxt;
  logic [31:0]                 ts, ts_lat;
  logic [NWORDS-1:0][15:0]     data_lat;
  logic                        ovf_lat;
  logic [IDXW-1:0]             idx;
  logic                        pop, last_word;
  logic [15:0]                 payload;

  assign sample_ready = (state == ST_IDLE) & enable;
  assign pop          = sample_valid & sample_ready;
  // Overflow records carry exactly one payload word (the dropped count).
  assign last_word    = ovf_lat | (idx == IDXW'(NWORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= 32'h0;
    else     ts <= ts + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ts_lat   <= 32'h0;
      data_lat <= '0;
      ovf_lat  <= 1'b0;
      idx      <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        ts_lat   <= ts;
        data_lat <= sample_data;
        ovf_lat  <= sample_overflow;
        idx      <= '0;
      end else if (state == ST_PAYLOAD && flit_ready && !last_word) begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  always_comb begin
    payload = data_lat[0];
    for (int i = 0; i < NWORDS; i++)
      if (!ovf_lat && idx == IDXW'(i)) payload = data_lat[i];
  end

  always_comb begin
    state_nxt  = state;
    flit_valid = 1'b0;
    flit_last  = 1'b0;
    flit_data  = 16'h0;
    unique case (state)
      ST_IDLE: if (pop) state_nxt = ST_DEST;
      ST_DEST: begin
        flit_valid = 1'b1;
        flit_data  = dest;
        if (flit_ready) state_nxt = ST_SRC;
      end
      ST_SRC: begin
        flit_valid = 1'b1;
        flit_data  = id;
        if (flit_ready) state_nxt = ST_FLAGS;
      end
      ST_FLAGS: begin
        flit_valid = 1'b1;
        flit_data  = flags_word(ovf_lat);
        if (flit_ready) state_nxt = ST_TS_LO;
      end
      ST_TS_LO: begin
        flit_valid = 1'b1;
        flit_data  = ts_lat[15:0];
        if (flit_ready) state_nxt = ST_TS_HI;
      end
      ST_TS_HI: begin
        flit_valid = 1'b1;
        flit_data  = ts_lat[31:16];
        if (flit_ready) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        flit_valid = 1'b1;
        flit_data  = payload;
        flit_last  = last_word;
        if (flit_ready && last_word) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_osd_tracepacket.sv
// Scoreboard bench for osd_tracepacket: a WIDTH=16 and a WIDTH=48 instance,
// expected flits queued at pop time and checked by per-instance monitors.
module tb_osd_tracepacket;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cmps = 0;
  int errs = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // ---------------- WIDTH=16 instance ----------------
  localparam logic [15:0] DEST16 = 16'h0000, ID16 = 16'h0012;
  logic        en16 = 1'b0, s16_valid = 1'b0, s16_ovf = 1'b0, rdy16, v16, l16, fr16;
  logic [15:0] s16_data = 16'h0, d16;
  logic        rnd16 = 1'b0, pre16 = 1'b0;
  logic [31:0] ts_m16;
  logic [16:0] q16[$];

  osd_tracepacket #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .id(ID16), .dest(DEST16), .enable(en16),
    .sample_data(s16_data), .sample_overflow(s16_ovf), .sample_valid(s16_valid),
    .sample_ready(rdy16), .flit_data(d16), .flit_last(l16), .flit_valid(v16),
    .flit_ready(fr16)
  );

  // ---------------- WIDTH=48 instance ----------------
  localparam logic [15:0] DEST48 = 16'hA5A5, ID48 = 16'h0033;
  logic        en48 = 1'b0, s48_valid = 1'b0, s48_ovf = 1'b0, rdy48, v48, l48, fr48;
  logic [47:0] s48_data = 48'h0;
  logic [15:0] d48;
  logic        rnd48 = 1'b0;
  logic [31:0] ts_m48;
  logic [16:0] q48[$];

  osd_tracepacket #(.WIDTH(48)) u48 (
    .clk(clk), .rst(rst), .id(ID48), .dest(DEST48), .enable(en48),
    .sample_data(s48_data), .sample_overflow(s48_ovf), .sample_valid(s48_valid),
    .sample_ready(rdy48), .flit_data(d48), .flit_last(l48), .flit_valid(v48),
    .flit_ready(fr48)
  );

  // Timestamp reference: free-running from reset; pre16 mirrors the forced wrap preload.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_m16 <= 32'h0;
      ts_m48 <= 32'h0;
    end else begin
      ts_m16 <= pre16 ? 32'hFFFF_FFFF : ts_m16 + 32'd1;
      ts_m48 <= ts_m48 + 32'd1;
    end
  end

  always @(posedge clk) begin
    #1;
    fr16 = rnd16 ? 1'($urandom_range(0, 1)) : 1'b1;
    fr48 = rnd48 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitors ----------------
  logic        stall16 = 1'b0, idle16 = 1'b0;
  logic [15:0] pd16 = 16'h0;
  logic [16:0] e16;
  always @(negedge clk) begin
    if (rst) begin
      stall16 = 1'b0; idle16 = 1'b0;
    end else begin
      if (idle16) begin
        chk("bubble16_valid", 64'(v16), 64'd0);
        chk("bubble16_ready", 64'(rdy16), 64'(en16));
        idle16 = 1'b0;
      end
      if (stall16) begin
        chk("stall16_valid", 64'(v16), 64'd1);
        chk("stall16_data", 64'(d16), 64'(pd16));
      end
      if (v16) chk("busy16_ready", 64'(rdy16), 64'd0);
      if (v16 && fr16) begin
        if (q16.size() == 0) begin
          cmps++; errs++;
          $display("FAIL extra16 actual=%h required=none", {l16, d16});
        end else begin
          e16 = q16.pop_front();
          chk("flit16", 64'({l16, d16}), 64'(e16));
          if (l16) idle16 = 1'b1;
        end
      end
      stall16 = v16 & ~fr16;
      pd16    = d16;
    end
  end

  logic        stall48 = 1'b0, idle48 = 1'b0;
  logic [15:0] pd48 = 16'h0;
  logic [16:0] e48;
  always @(negedge clk) begin
    if (rst) begin
      stall48 = 1'b0; idle48 = 1'b0;
    end else begin
      if (idle48) begin
        chk("bubble48_valid", 64'(v48), 64'd0);
        chk("bubble48_ready", 64'(rdy48), 64'(en48));
        idle48 = 1'b0;
      end
      if (stall48) begin
        chk("stall48_valid", 64'(v48), 64'd1);
        chk("stall48_data", 64'(d48), 64'(pd48));
      end
      if (v48) chk("busy48_ready", 64'(rdy48), 64'd0);
      if (v48 && fr48) begin
        if (q48.size() == 0) begin
          cmps++; errs++;
          $display("FAIL extra48 actual=%h required=none", {l48, d48});
        end else begin
          e48 = q48.pop_front();
          chk("flit48", 64'({l48, d48}), 64'(e48));
          if (l48) idle48 = 1'b1;
        end
      end
      stall48 = v48 & ~fr48;
      pd48    = d48;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic pop16(input logic [15:0] d, input logic ovf, input bit preload);
    int n = 0;
    logic [31:0] ets;
    @(posedge clk); #1;
    while (!rdy16 && n < 300) begin @(posedge clk); #1; n++; end
    if (!rdy16) begin
      cmps++; errs++;
      $display("FAIL pop16_timeout actual=%0b required=1", rdy16);
    end else begin
      if (preload) begin
        force u16.ts = 32'hFFFF_FFFF;
        pre16 = 1'b1;
      end
      ets = preload ? 32'hFFFF_FFFF : ts_m16;
      s16_data = d; s16_ovf = ovf; s16_valid = 1'b1;
      q16.push_back({1'b0, DEST16});
      q16.push_back({1'b0, ID16});
      q16.push_back({1'b0, (ovf ? 16'h9400 : 16'h8000)});
      q16.push_back({1'b0, ets[15:0]});
      q16.push_back({1'b0, ets[31:16]});
      q16.push_back({1'b1, d});
      @(posedge clk); #1;
      s16_valid = 1'b0; s16_data = ~d; s16_ovf = ~ovf;
      if (preload) begin
        release u16.ts;
        pre16 = 1'b0;
      end
    end
  endtask

  task automatic pop48(input logic [47:0] d, input logic ovf);
    int n = 0;
    logic [31:0] ets;
    @(posedge clk); #1;
    while (!rdy48 && n < 300) begin @(posedge clk); #1; n++; end
    if (!rdy48) begin
      cmps++; errs++;
      $display("FAIL pop48_timeout actual=%0b required=1", rdy48);
    end else begin
      ets = ts_m48;
      s48_data = d; s48_ovf = ovf; s48_valid = 1'b1;
      q48.push_back({1'b0, DEST48});
      q48.push_back({1'b0, ID48});
      q48.push_back({1'b0, (ovf ? 16'h9400 : 16'h8000)});
      q48.push_back({1'b0, ets[15:0]});
      q48.push_back({1'b0, ets[31:16]});
      if (ovf) q48.push_back({1'b1, d[15:0]});
      else for (int i = 0; i < 3; i++) q48.push_back({(i == 2), d[i*16 +: 16]});
      @(posedge clk); #1;
      s48_valid = 1'b0; s48_data = ~d; s48_ovf = ~ovf;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q16.size() != 0 || q48.size() != 0) && n < 1000) begin @(posedge clk); n++; end
    repeat (2) @(posedge clk);
    chk("drain16", 64'(q16.size()), 64'd0);
    chk("drain48", 64'(q48.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid16", 64'(v16), 64'd0);
    chk("rst_last16", 64'(l16), 64'd0);
    chk("rst_data16", 64'(d16), 64'd0);
    chk("rst_ready16", 64'(rdy16), 64'd0);
    chk("rst_valid48", 64'(v48), 64'd0);
    chk("rst_ready48", 64'(rdy48), 64'd0);
    rst = 1'b0;
    en16 = 1'b1; en48 = 1'b1;
    #1;
    chk("idle_ready16", 64'(rdy16), 64'd1);
    chk("idle_ready48", 64'(rdy48), 64'd1);

    // Directed packets: event and overflow on both widths.
    pop16(16'hBEEF, 1'b0, 1'b0);
    pop16(16'h0007, 1'b1, 1'b0);
    pop48(48'h1111_2222_3333, 1'b0);
    pop48(48'hFFFF_FFFF_0012, 1'b1);
    wait_drain();

    // Random backpressure on both instances concurrently.
    rnd16 = 1'b1; rnd48 = 1'b1;
    fork
      begin
        pop16(16'h1357, 1'b0, 1'b0);
        pop16(16'h00FF, 1'b1, 1'b0);
        pop16(16'h2468, 1'b0, 1'b0);
        pop16(16'hA5A5, 1'b0, 1'b0);
      end
      begin
        pop48(48'hABCD_0123_4567, 1'b0);
        pop48(48'h0000_0000_0003, 1'b1);
        pop48(48'h8000_0001_7FFE, 1'b0);
      end
    join
    wait_drain();
    rnd16 = 1'b0; rnd48 = 1'b0;

    // Enable dropped mid-packet: packet finishes, held entry is not popped.
    pop16(16'h1234, 1'b0, 1'b0);
    en16 = 1'b0;
    s16_data = 16'h5678; s16_valid = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("en_off_queue", 64'(q16.size()), 64'd0);
    chk("en_off_ready", 64'(rdy16), 64'd0);
    chk("en_off_valid", 64'(v16), 64'd0);
    s16_valid = 1'b0;
    en16 = 1'b1;
    pop16(16'h5678, 1'b0, 1'b0);
    wait_drain();

    // Reset while presenting TS_LO.
    pop16(16'hCAFE, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_valid", 64'(v16), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(v16), 64'd0);
    chk("mid_rst_last", 64'(l16), 64'd0);
    q16.delete();
    q48.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(rdy16), 64'd1);
    chk("post_rst_valid", 64'(v16), 64'd0);
    pop16(16'hBEEF, 1'b0, 1'b0);
    wait_drain();

    // Timestamp wrap: pop at 0xFFFFFFFF, then a small wrapped value.
    pop16(16'h0101, 1'b0, 1'b1);
    pop16(16'h0202, 1'b0, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
